// File: rtl/iwrr_pkg.sv
// Shared types and constants for the IWRR client bank: FSM state encoding,
// default configuration and the width helpers derived from it.
package iwrr_pkg;

  localparam int DEF_REQUESTER_NUM = 3;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_FIFO_DEPTH    = 4;

  // Width of an index into n items; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int REQ_NUM_W = clog2_min1(DEF_REQUESTER_NUM);
  localparam int PTR_W     = clog2_min1(DEF_FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_CAPTURE   = 3'd4
  } state_e;

endpackage

// File: rtl/iwrr_client_fifo.sv
// Per-requester FIFO: power-of-two depth, wrap-bit pointers, combinational head.
// A push into a full FIFO is refused even if the same cycle pops it.
module iwrr_client_fifo
  import iwrr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // The extra top bit distinguishes a full lap from an empty FIFO.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/iwrr_client_bank.sv
// Client side of an IWRR arbiter: per-channel FIFOs, request generation and a
// grant-driven single-entry transfer FSM. Option: IWRR_CLIENT_OUT_REG_EN.
module iwrr_client_bank
  import iwrr_pkg::*;
#(
  parameter int P_REQUESTER_NUM = DEF_REQUESTER_NUM,
  parameter int P_DATA_W        = DEF_DATA_W,
  parameter int P_FIFO_DEPTH    = DEF_FIFO_DEPTH,
  localparam int ID_W           = clog2_min1(P_REQUESTER_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [P_REQUESTER_NUM-1:0]      in_valid,
  output logic [P_REQUESTER_NUM-1:0]      in_ready,
  input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] in_data,
  output logic [P_REQUESTER_NUM-1:0]      request,
  input  logic [P_REQUESTER_NUM-1:0]      grant_valid,
  output logic                            grant_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [P_DATA_W-1:0]             out_data,
  output logic [ID_W-1:0]                 out_src_id,
  output logic                            proto_err
);

  localparam logic [P_REQUESTER_NUM-1:0] VEC_ONE = {{(P_REQUESTER_NUM-1){1'b0}}, 1'b1};

  logic [P_DATA_W-1:0]        head [P_REQUESTER_NUM];
  logic [P_REQUESTER_NUM-1:0] full;
  logic [P_REQUESTER_NUM-1:0] empty;
  logic [P_REQUESTER_NUM-1:0] pop;

  state_e          state_q, state_d;
  logic [ID_W-1:0] gidx_q, gidx_d;
  logic [ID_W-1:0] grant_idx;
  logic            grant_none;
  logic            grant_multi;
  logic            pop_en;
  logic            err_set;
  logic            err_q;

  for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_ch
    iwrr_client_fifo #(
      .DATA_W (P_DATA_W),
      .DEPTH  (P_FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[i]),
      .push_data (in_data[i*P_DATA_W +: P_DATA_W]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
    assign pop[i] = pop_en && (gidx_q == ID_W'(i));
  end

  // Requests come purely from registered FIFO state, never from grant_valid.
  assign in_ready = ~full;
  assign request  = ~empty;

  assign grant_none  = (grant_valid == '0);
  assign grant_multi = |(grant_valid & (grant_valid - VEC_ONE));

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < P_REQUESTER_NUM; i++) begin
      if (grant_valid[i]) grant_idx = ID_W'(i);
    end
  end

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    err_set = 1'b0;
    pop_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_multi) begin
          err_set = 1'b1;
        end else if (!grant_none) begin
          gidx_d = grant_idx;
          if (empty[grant_idx]) begin
            err_set = 1'b1;
            state_d = ST_RELEASE;
          end else begin
`ifdef IWRR_CLIENT_OUT_REG_EN
            state_d = ST_CAPTURE;
`else
            state_d = ST_SEND;
`endif
          end
        end
      end
`ifdef IWRR_CLIENT_OUT_REG_EN
      ST_CAPTURE: begin
        pop_en  = 1'b1;
        state_d = ST_SEND;
      end
`endif
      ST_SEND: begin
        if (out_ready) begin
`ifndef IWRR_CLIENT_OUT_REG_EN
          pop_en = 1'b1;
`endif
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE:   state_d = ST_WAIT_DROP;
      ST_WAIT_DROP: if (grant_none) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign out_valid   = (state_q == ST_SEND);
  assign grant_ready = (state_q == ST_RELEASE);
  assign out_src_id  = gidx_q;
  assign proto_err   = err_q;

`ifdef IWRR_CLIENT_OUT_REG_EN
  logic [P_DATA_W-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (pop_en) begin
      out_q <= head[gidx_q];
    end
  end

  assign out_data = out_q;
`else
  // Head is only meaningful while sending; keep the bus quiet otherwise.
  assign out_data = out_valid ? head[gidx_q] : '0;
`endif

endmodule

// File: doc/iwrr_client_bank.md
IWRR_CLIENT_BANK -- requirements
Module: iwrr_client_bank

Interface
REQ-001 The block SHALL have parameter P_REQUESTER_NUM, default 3: number of requester channels.
REQ-002 The block SHALL have parameter P_DATA_W, default 32: payload width per transaction.
REQ-003 The block SHALL have parameter P_FIFO_DEPTH, default 4: per-channel FIFO depth, power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, P_REQUESTER_NUM bits: per-channel write strobe.
REQ-007 The block SHALL have port in_ready, output, P_REQUESTER_NUM bits: per-channel FIFO not full.
REQ-008 The block SHALL have port in_data, input, P_REQUESTER_NUM*P_DATA_W bits: channel i occupies bits [i*P_DATA_W +: P_DATA_W].
REQ-009 The block SHALL have port request, output, P_REQUESTER_NUM bits: to the arbiter; bit i means FIFO i is non-empty.
REQ-010 The block SHALL have port grant_valid, input, P_REQUESTER_NUM bits: registered one-hot grant from the arbiter.
REQ-011 The block SHALL have port grant_ready, output, 1 bit: a one-cycle pulse releasing the current grant.
REQ-012 The block SHALL have port out_valid, input out_ready, and output out_data of P_DATA_W bits: a shared downstream valid/ready channel.
REQ-013 The block SHALL have port out_src_id, output, $clog2(P_REQUESTER_NUM) bits: index of the channel that sourced out_data.
REQ-014 The block SHALL have port proto_err, output, 1 bit: sticky error flag.

Function
REQ-015 The block SHALL write FIFO i on in_valid[i]&in_ready[i], with in_ready[i] = ~full[i]; a write to a full FIFO SHALL be refused even when that FIFO is popped in the same cycle.
REQ-016 request[i] SHALL equal ~empty[i], driven from registered FIFO state with no combinational path from grant_valid.
REQ-017 The FSM SHALL have states IDLE, SEND, RELEASE and WAIT_DROP, plus CAPTURE when REQ-030 applies.
REQ-018 In IDLE, when grant_valid is one-hot, the FSM SHALL latch the granted index into a grant-index register and enter SEND.
REQ-019 In IDLE, when grant_valid is zero, the FSM SHALL stay in IDLE.
REQ-020 In IDLE, when grant_valid has more than one bit set, the block SHALL set proto_err, assert no grant_ready and stay in IDLE.
REQ-021 In IDLE, when a one-hot grant selects an empty FIFO, the block SHALL set proto_err and go directly to RELEASE without any output transfer.
REQ-022 In SEND, out_valid SHALL be 1, and out_data and out_src_id SHALL be held stable until out_ready.
REQ-023 In SEND, on out_valid&out_ready the block SHALL pop the granted FIFO and enter RELEASE.
REQ-024 In RELEASE, grant_ready SHALL be 1 for exactly one cycle, after which the FSM SHALL enter WAIT_DROP.
REQ-025 In WAIT_DROP, the FSM SHALL enter IDLE once grant_valid is all zero, so a stale grant is never reused.
REQ-026 Latency without REQ-030: grant_valid seen in cycle t SHALL give out_valid in cycle t+1.
REQ-027 The block SHALL transfer exactly one FIFO entry per grant.
REQ-028 FIFO pointers SHALL wrap modulo P_FIFO_DEPTH, with an extra bit used to tell full from empty.

Reset
REQ-029 While rst is high, the block SHALL hold the FSM in IDLE, empty all FIFOs, and drive request=0, grant_ready=0, out_valid=0, out_data=0, out_src_id=0, proto_err=0 and in_ready=all ones on the next edge; reset mid-transfer SHALL drop the in-flight entry.

Configuration
REQ-030 With macro IWRR_CLIENT_OUT_REG_EN defined, IDLE SHALL go to CAPTURE, which pops the FIFO head into an output register and then enters SEND; SEND SHALL not pop again, and latency SHALL become t+2.
REQ-031 Without IWRR_CLIENT_OUT_REG_EN, out_data SHALL be driven from the granted FIFO head through a mux selected by the grant-index register, as in REQ-026.

Structure
REQ-032 Package iwrr_pkg SHALL hold the FSM state enum and the helper constants REQ_NUM_W and PTR_W.
REQ-033 The per-channel FIFO SHALL be a sub-module named iwrr_client_fifo, instantiated P_REQUESTER_NUM times by a generate loop.

Verification
REQ-034 The bench SHALL cover this scenario: push 0xA5 to channel 1, then grant_valid=3'b010 at cycle t -> request=3'b010, out_valid at t+1 with out_data=0xA5 and out_src_id=1, grant_ready pulse, then request=3'b000.
REQ-035 The bench SHALL cover this scenario: out_ready held low for 5 cycles during SEND -> out_data stable and grant_ready=0 throughout, then a single pulse after the handshake.
REQ-036 The bench SHALL cover this scenario: fill channel 0 with 4 entries -> in_ready[0]=0; then in_valid[0] together with a pop -> write refused and count 3.
REQ-037 The bench SHALL cover this scenario: grant_valid=3'b011 -> proto_err=1, no grant_ready and no out_valid; an empty-channel grant -> proto_err=1 and a grant_ready pulse.
REQ-038 The bench SHALL cover this scenario: connected to a 3-requester weight {5,3,2} arbiter with all FIFOs kept full for 20 grants -> per-channel grant counts of 10/6/4 and no proto_err.
REQ-039 The bench SHALL cover this scenario: rst asserted in SEND -> next cycle out_valid=0, request=0 and FSM in IDLE; with IWRR_CLIENT_OUT_REG_EN, REQ-034 gives out_valid at t+2.
